// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared control codes, opcodes and sequencer states for the ULA datapath
package ula_pkg;

    localparam logic [3:0] CLEAR = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] HOLD  = 4'd2;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_AND       = 3'd2;
    localparam logic [2:0] OP_OR        = 3'd3;
    localparam logic [2:0] OP_XOR       = 3'd4;
    localparam logic [2:0] OP_NOT_X     = 3'd5;
    localparam logic [2:0] OP_PASS_Y    = 3'd6;
    localparam logic [2:0] OP_CLEAR_ALL = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LDX  = 3'd2,
        LDY  = 3'd3,
        EXEC = 3'd4,
        FIM  = 3'd5
    } estado_t;

endpackage

// File: rtl/decodifica_op.sv
// rtl/decodifica_op.sv - maps an opcode to the first sequencer state and the unary flag
module decodifica_op
    import ula_pkg::*;
#(
    parameter int W_OP = 3
) (
    input  logic [W_OP-1:0] op,
    output estado_t         primeiro,
    output logic            unario
);

    always_comb begin
        primeiro = LDX;
        unario   = 1'b0;
        if (op == W_OP'(OP_CLEAR_ALL)) begin
            primeiro = CLR;
        end else if (op == W_OP'(OP_PASS_Y)) begin
            primeiro = LDY;
        end
        // only X feeds NOT_X, so Y is skipped after the X load
        if (op == W_OP'(OP_NOT_X)) begin
            unario = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle_regs.sv
// rtl/unidade_controle_regs.sv - sequencer driving X/Y/Z register codes and ULA select
module unidade_controle_regs
    import ula_pkg::*;
#(
    parameter int W_CTRL = 4,
    parameter int W_OP   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [W_OP-1:0]   op,
    input  logic              dado_valido,
    output logic              dado_pronto,
    output logic [W_CTRL-1:0] tx,
    output logic [W_CTRL-1:0] ty,
    output logic [W_CTRL-1:0] tz,
    output logic [W_OP-1:0]   sel_ula,
    output logic              busy,
    output logic              done
);

    localparam logic [W_CTRL-1:0] C_CLEAR = W_CTRL'(CLEAR);
    localparam logic [W_CTRL-1:0] C_LOAD  = W_CTRL'(LOAD);
    localparam logic [W_CTRL-1:0] C_HOLD  = W_CTRL'(HOLD);

    estado_t         estado;
    estado_t         proximo;
    estado_t         primeiro;
    logic            unario;
    logic            unario_reg;
    logic [W_OP-1:0] op_reg;

    decodifica_op #(
        .W_OP(W_OP)
    ) u_decodifica_op (
        .op      (op),
        .primeiro(primeiro),
        .unario  (unario)
    );

    // the unary flag is captured with the opcode so LDX never re-decodes op_reg
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            op_reg     <= '0;
            unario_reg <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == IDLE && start) begin
                op_reg     <= op;
                unario_reg <= unario;
            end
        end
    end

    always_comb begin
        proximo     = estado;
        tx          = C_HOLD;
        ty          = C_HOLD;
        tz          = C_HOLD;
        sel_ula     = op_reg;
        busy        = 1'b1;
        done        = 1'b0;
        dado_pronto = 1'b0;
        unique case (estado)
            IDLE: begin
                sel_ula = '0;
                busy    = 1'b0;
                if (start) begin
                    proximo = primeiro;
                end
            end
            CLR: begin
                tx      = C_CLEAR;
                ty      = C_CLEAR;
                tz      = C_CLEAR;
                proximo = FIM;
            end
            LDX: begin
                if (dado_valido) begin
                    tx          = C_LOAD;
                    dado_pronto = 1'b1;
                    proximo     = unario_reg ? EXEC : LDY;
                end
            end
            LDY: begin
                if (dado_valido) begin
                    ty          = C_LOAD;
                    dado_pronto = 1'b1;
                    proximo     = EXEC;
                end
            end
            EXEC: begin
                tz      = C_LOAD;
                proximo = FIM;
            end
            FIM: begin
                done    = 1'b1;
                proximo = IDLE;
            end
            default: begin
                proximo = IDLE;
            end
        endcase
    end

endmodule
